lbp_window_buffer: RTL

Streaming 3x3 neighbourhood generator between the pixel readout stage (`pixel_macro`) and the local-binary-pattern stage (`rlbp_macro`) inside `user_project_wrapper`. It accepts raster-order pixels over a valid/ready handshake and stores the two previous image rows in line buffers. For every fully interior pixel position it emits one centre pixel plus its 8 neighbours, giving the LBP stage a complete window per transfer. It runs on the wrapper's Wishbone clock domain.

---
 rtl/lbp_window_buffer.sv | 95 +++++++++
 1 files changed

// File: rtl/lbp_window_buffer.sv
// rtl/lbp_window_buffer.sv - streaming 3x3 neighbourhood generator feeding the LBP stage
module lbp_window_buffer #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               pix_valid_i,
    input  logic [PIX_W-1:0]   pix_data_i,
    input  logic               frame_start_i,
    output logic               pix_ready_o,
    output logic               win_valid_o,
    input  logic               win_ready_i,
    output logic [PIX_W-1:0]   win_center_o,
    output logic [8*PIX_W-1:0] win_neigh_o,
    output logic [7:0]         win_row_o,
    output logic [7:0]         win_col_o
);
    localparam int CW = $clog2(IMG_W);

    logic [CW-1:0]    col;
    logic [CW-1:0]    cur_col;
    logic [7:0]       row;
    logic [7:0]       cur_row;
    logic [7:0]       row_nxt;
    logic             rows_ok;
    logic             cur_rows_ok;
    logic             accept;
    logic             emit;
    logic             col_wrap;

    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];
    logic [PIX_W-1:0] lb1_rd;
    logic [PIX_W-1:0] lb2_rd;

    // Two previously accepted columns; index 0 is the top row (r-2).
    logic [2:0][PIX_W-1:0] wm;
    logic [2:0][PIX_W-1:0] wr;

    assign pix_ready_o = !wb_rst_i && (!win_valid_o || win_ready_i);
    assign accept      = pix_valid_i && pix_ready_o;

    // A frame-start pixel takes position (0,0) regardless of the counters.
    assign cur_col     = frame_start_i ? '0 : col;
    assign cur_row     = frame_start_i ? 8'd0 : row;
    assign cur_rows_ok = frame_start_i ? 1'b0 : rows_ok;

    assign col_wrap = (cur_col == CW'(IMG_W - 1));
    assign row_nxt  = col_wrap ? cur_row + 8'd1 : cur_row;
    assign emit     = accept && (cur_rows_ok || cur_row >= 8'd2) && (cur_col >= CW'(2));

    assign lb1_rd = lb1[cur_col];
    assign lb2_rd = lb2[cur_col];

    always_ff @(posedge wb_clk_i) begin
        if (accept) begin
            lb2[cur_col] <= lb1_rd;
            lb1[cur_col] <= pix_data_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            col          <= '0;
            row          <= 8'd0;
            rows_ok      <= 1'b0;
            wm           <= '0;
            wr           <= '0;
            win_valid_o  <= 1'b0;
            win_center_o <= '0;
            win_neigh_o  <= '0;
            win_row_o    <= 8'd0;
            win_col_o    <= 8'd0;
        end else begin
            if (accept) begin
                col     <= col_wrap ? '0 : cur_col + CW'(1);
                row     <= row_nxt;
                rows_ok <= cur_rows_ok || (row_nxt == 8'd2);
                wm      <= frame_start_i ? '0 : wr;
                wr      <= {pix_data_i, lb1_rd, lb2_rd};
            end
            if (emit) begin
                // Neighbours n7..n0 = L, BL, B, BR, R, TR, T, TL
                win_valid_o  <= 1'b1;
                win_center_o <= wr[1];
                win_neigh_o  <= {wm[1], wm[2], wr[2], pix_data_i, lb1_rd, lb2_rd, wr[0], wm[0]};
                win_row_o    <= cur_row - 8'd1;
                win_col_o    <= 8'(cur_col - CW'(1));
            end else if (win_ready_i) begin
                win_valid_o <= 1'b0;
            end
        end
    end
endmodule
